// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pkg : shared raster widths, default timing and sprite colours  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int X_W              = 10;
  localparam int Y_W              = 9;

  typedef enum logic [2:0] {
    COLOR_BLACK   = 3'b000,
    COLOR_BLUE    = 3'b001,
    COLOR_GREEN   = 3'b010,
    COLOR_CYAN    = 3'b011,
    COLOR_RED     = 3'b100,
    COLOR_MAGENTA = 3'b101,
    COLOR_YELLOW  = 3'b110,
    COLOR_WHITE   = 3'b111
  } color_e;

  // Black would make the sprite invisible, so the cycle skips it.
  function automatic color_e next_color(color_e c);
    return (c == COLOR_WHITE) ? COLOR_BLUE : color_e'(c + 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/logo_bounce_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | logo_bounce_controller_if : raster inputs and sprite outputs       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface logo_bounce_controller_if;

  logic [vga_pkg::X_W-1:0] x_i;
  logic [vga_pkg::Y_W-1:0] y_i;
  logic                    vsync_i;
  logic [vga_pkg::X_W-1:0] lut_x_o;
  logic [vga_pkg::Y_W-1:0] lut_y_o;
  logic                    sprite_hit_o;
  logic [2:0]              color_o;
  logic [vga_pkg::X_W-1:0] pos_x_o;
  logic [vga_pkg::Y_W-1:0] pos_y_o;
  logic                    bounce_o;
  logic                    corner_o;

  modport master (
    output x_i, y_i, vsync_i,
    input  lut_x_o, lut_y_o, sprite_hit_o, color_o, pos_x_o, pos_y_o, bounce_o, corner_o
  );

  modport slave (
    input  x_i, y_i, vsync_i,
    output lut_x_o, lut_y_o, sprite_hit_o, color_o, pos_x_o, pos_y_o, bounce_o, corner_o
  );

endinterface
`default_nettype wire

// File: rtl/bounce_axis.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bounce_axis : one-axis sprite origin that reflects off 0 and MAX   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bounce_axis #(
  parameter int WIDTH = 10,
  parameter int MAX   = 512,
  parameter int STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             move_i,
  output logic [WIDTH-1:0] pos_o,
  output logic             bounce_o
);

  localparam logic [WIDTH:0]   c_MAX_EXT  = MAX[WIDTH:0];
  localparam logic [WIDTH:0]   c_STEP_EXT = STEP[WIDTH:0];
  localparam logic [WIDTH-1:0] c_MAX      = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_STEP     = STEP[WIDTH-1:0];

  logic [WIDTH-1:0] r_pos;
  logic             r_dir_dec;
  logic [WIDTH:0]   w_inc;
  logic             w_wall_hi;
  logic             w_wall_lo;

  // One extra bit keeps pos+STEP from wrapping before the limit compare.
  always_comb begin
    w_inc     = {1'b0, r_pos} + c_STEP_EXT;
    w_wall_hi = !r_dir_dec && (w_inc > c_MAX_EXT);
    w_wall_lo =  r_dir_dec && ({1'b0, r_pos} < c_STEP_EXT);
  end

  assign bounce_o = move_i && (w_wall_hi || w_wall_lo);
  assign pos_o    = r_pos;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pos     <= '0;
      r_dir_dec <= 1'b0;
    end else if (move_i) begin
      if (w_wall_hi) begin
        r_pos     <= c_MAX;
        r_dir_dec <= 1'b1;
      end else if (w_wall_lo) begin
        r_pos     <= '0;
        r_dir_dec <= 1'b0;
      end else if (r_dir_dec) begin
        r_pos <= r_pos - c_STEP;
      end else begin
        r_pos <= w_inc[WIDTH-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/logo_bounce_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | logo_bounce_controller : per-frame sprite motion and window mapping|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module logo_bounce_controller
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE        = V_ACTIVE_DEFAULT,
  parameter int SPRITE_W        = 128,
  parameter int SPRITE_H        = 64,
  parameter int STEP_X          = 1,
  parameter int STEP_Y          = 1,
  parameter int FRAME_DIV       = 1,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  logo_bounce_controller_if.slave bus
);

  localparam int                 c_MAX_X    = H_ACTIVE - SPRITE_W;
  localparam int                 c_MAX_Y    = V_ACTIVE - SPRITE_H;
  localparam int                 c_DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(FRAME_DIV - 1);
  localparam logic               c_VS_ACT   = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [X_W:0]       c_SPR_W    = SPRITE_W[X_W:0];
  localparam logic [Y_W:0]       c_SPR_H    = SPRITE_H[Y_W:0];

  logic               r_vsync_q;
  logic [c_DIV_W-1:0] r_div;
  logic               w_tick;
  logic               w_move;
  logic               w_bounce_x;
  logic               w_bounce_y;
  logic [X_W-1:0]     w_pos_x;
  logic [Y_W-1:0]     w_pos_y;
  color_e             r_color;
  logic               r_bounce;
  logic               r_corner;
  logic               r_hit;
  logic [X_W-1:0]     r_lut_x;
  logic [Y_W-1:0]     r_lut_y;
  logic [X_W:0]       w_x_end;
  logic [Y_W:0]       w_y_end;
  logic               w_hit;

  // vsync_q resets to the active level so a sync held through reset is not a tick.
  assign w_tick = (bus.vsync_i == c_VS_ACT) && (r_vsync_q != c_VS_ACT);
  assign w_move = w_tick && (r_div == c_DIV_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vsync_q <= c_VS_ACT;
      r_div     <= '0;
    end else begin
      r_vsync_q <= bus.vsync_i;
      if (w_tick) begin
        r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
      end
    end
  end

  bounce_axis #(.WIDTH(X_W), .MAX(c_MAX_X), .STEP(STEP_X)) u_axis_x (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .move_i   (w_move),
    .pos_o    (w_pos_x),
    .bounce_o (w_bounce_x)
  );

  bounce_axis #(.WIDTH(Y_W), .MAX(c_MAX_Y), .STEP(STEP_Y)) u_axis_y (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .move_i   (w_move),
    .pos_o    (w_pos_y),
    .bounce_o (w_bounce_y)
  );

  // A corner counts as one bounce, so the colour steps only once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_color  <= COLOR_BLUE;
      r_bounce <= 1'b0;
      r_corner <= 1'b0;
    end else begin
      r_bounce <= w_bounce_x || w_bounce_y;
      r_corner <= w_bounce_x && w_bounce_y;
      if (w_bounce_x || w_bounce_y) begin
        r_color <= next_color(r_color);
      end
    end
  end

  always_comb begin
    w_x_end = {1'b0, w_pos_x} + c_SPR_W;
    w_y_end = {1'b0, w_pos_y} + c_SPR_H;
    w_hit   = ({1'b0, bus.x_i} >= {1'b0, w_pos_x}) && ({1'b0, bus.x_i} < w_x_end) &&
              ({1'b0, bus.y_i} >= {1'b0, w_pos_y}) && ({1'b0, bus.y_i} < w_y_end);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hit   <= 1'b0;
      r_lut_x <= '0;
      r_lut_y <= '0;
    end else begin
      r_hit   <= w_hit;
      r_lut_x <= w_hit ? (bus.x_i - w_pos_x) : '0;
      r_lut_y <= w_hit ? (bus.y_i - w_pos_y) : '0;
    end
  end

  assign bus.lut_x_o      = r_lut_x;
  assign bus.lut_y_o      = r_lut_y;
  assign bus.sprite_hit_o = r_hit;
  assign bus.color_o      = r_color;
  assign bus.pos_x_o      = w_pos_x;
  assign bus.pos_y_o      = w_pos_y;
  assign bus.bounce_o     = r_bounce;
  assign bus.corner_o     = r_corner;

endmodule
`default_nettype wire

// File: tb/tb_logo_bounce_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_logo_bounce_controller : scoreboard bench, three configurations |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_logo_bounce_controller;

  localparam int F_HIT = 0, F_LX = 1, F_LY = 2, F_PX = 3, F_PY = 4, F_COL = 5, F_BNC = 6, F_CRN = 7;

  typedef struct {
    int x; int y; bit dx; bit dy; int col; int div; bit bx; bit by;
  } mstate_t;

  typedef struct {
    string       tag;
    int          d;
    int          f;
    int unsigned v;
  } exp_t;

  logic clk;
  logic rst_a, rst_c, rst_d;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb_q[$];
  mstate_t ms[3];
  int unsigned obs[3][8];
  int   max_x[3] = '{512, 400, 512};
  int   max_y[3] = '{416, 400, 416};
  int   fdiv[3]  = '{1, 1, 3};
  string dn[3]   = '{"a", "c", "d"};

  logo_bounce_controller_if if_a ();
  logo_bounce_controller_if if_c ();
  logo_bounce_controller_if if_d ();

  logo_bounce_controller u_dut_a (.clk_i(clk), .rst_i(rst_a), .bus(if_a.slave));
  logo_bounce_controller #(.SPRITE_W(240), .SPRITE_H(80)) u_dut_c (
    .clk_i(clk), .rst_i(rst_c), .bus(if_c.slave));
  logo_bounce_controller #(.FRAME_DIV(3)) u_dut_d (.clk_i(clk), .rst_i(rst_d), .bus(if_d.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs[0] = '{32'(if_a.sprite_hit_o), 32'(if_a.lut_x_o), 32'(if_a.lut_y_o), 32'(if_a.pos_x_o),
               32'(if_a.pos_y_o), 32'(if_a.color_o), 32'(if_a.bounce_o), 32'(if_a.corner_o)};
    obs[1] = '{32'(if_c.sprite_hit_o), 32'(if_c.lut_x_o), 32'(if_c.lut_y_o), 32'(if_c.pos_x_o),
               32'(if_c.pos_y_o), 32'(if_c.color_o), 32'(if_c.bounce_o), 32'(if_c.corner_o)};
    obs[2] = '{32'(if_d.sprite_hit_o), 32'(if_d.lut_x_o), 32'(if_d.lut_y_o), 32'(if_d.pos_x_o),
               32'(if_d.pos_y_o), 32'(if_d.color_o), 32'(if_d.bounce_o), 32'(if_d.corner_o)};
  end

  task automatic check_val(string tag, int unsigned act, int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_exp(int d, int f, string name, int unsigned v);
    exp_t e;
    e.tag = $sformatf("%s.%s", dn[d], name);
    e.d = d; e.f = f; e.v = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, obs[e.d][e.f], e.v);
    end
  endtask

  function automatic mstate_t model_init();
    mstate_t s;
    s.x = 0; s.y = 0; s.dx = 0; s.dy = 0; s.col = 1; s.div = 0; s.bx = 0; s.by = 0;
    return s;
  endfunction

  function automatic mstate_t model_step(mstate_t s, int mx, int my, int fd);
    mstate_t n = s;
    n.bx = 0; n.by = 0;
    if (s.div != fd - 1) begin
      n.div = s.div + 1;
      return n;
    end
    n.div = 0;
    if (!s.dx) begin
      if (s.x + 1 > mx) begin n.x = mx; n.dx = 1; n.bx = 1; end else n.x = s.x + 1;
    end else begin
      if (s.x < 1) begin n.x = 0; n.dx = 0; n.bx = 1; end else n.x = s.x - 1;
    end
    if (!s.dy) begin
      if (s.y + 1 > my) begin n.y = my; n.dy = 1; n.by = 1; end else n.y = s.y + 1;
    end else begin
      if (s.y < 1) begin n.y = 0; n.dy = 0; n.by = 1; end else n.y = s.y - 1;
    end
    if (n.bx || n.by) n.col = (s.col == 7) ? 1 : s.col + 1;
    return n;
  endfunction

  task automatic set_vs(int d, logic v);
    case (d)
      0: if_a.vsync_i = v;
      1: if_c.vsync_i = v;
      default: if_d.vsync_i = v;
    endcase
  endtask

  task automatic expect_state(int d, int x, int y, int col);
    push_exp(d, F_PX, "pos_x", x);
    push_exp(d, F_PY, "pos_y", y);
    push_exp(d, F_COL, "color", col);
    drain();
  endtask

  // Active-low sync: a one-cycle low pulse is one frame tick.
  task automatic pulse(int d);
    set_vs(d, 1'b0);
    ms[d] = model_step(ms[d], max_x[d], max_y[d], fdiv[d]);
    @(negedge clk);
    push_exp(d, F_PX, "pos_x", ms[d].x);
    push_exp(d, F_PY, "pos_y", ms[d].y);
    push_exp(d, F_COL, "color", ms[d].col);
    push_exp(d, F_BNC, "bounce", 32'(ms[d].bx | ms[d].by));
    push_exp(d, F_CRN, "corner", 32'(ms[d].bx & ms[d].by));
    drain();
    set_vs(d, 1'b1);
    @(negedge clk);
    push_exp(d, F_BNC, "bounce_drop", 0);
    push_exp(d, F_CRN, "corner_drop", 0);
    drain();
  endtask

  task automatic pix(int x, int y, int h, int lx, int ly);
    if_a.x_i = 10'(x);
    if_a.y_i = 9'(y);
    push_exp(0, F_HIT, $sformatf("hit@%0d,%0d", x, y), h);
    push_exp(0, F_LX, $sformatf("lut_x@%0d,%0d", x, y), lx);
    push_exp(0, F_LY, $sformatf("lut_y@%0d,%0d", x, y), ly);
    @(negedge clk);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) ms[i] = model_init();
    rst_a = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    if_a.x_i = '0; if_a.y_i = '0; if_a.vsync_i = 1'b1;
    if_c.x_i = '0; if_c.y_i = '0; if_c.vsync_i = 1'b1;
    if_d.x_i = '0; if_d.y_i = '0; if_d.vsync_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push_exp(0, F_HIT, "rst_hit", 0);
    push_exp(0, F_LX, "rst_lut_x", 0);
    push_exp(0, F_LY, "rst_lut_y", 0);
    push_exp(0, F_BNC, "rst_bounce", 0);
    push_exp(0, F_CRN, "rst_corner", 0);
    drain();
    expect_state(0, 0, 0, 1);
    rst_a = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    @(negedge clk);
    push_exp(0, F_HIT, "rel_hit", 1);
    push_exp(0, F_LX, "rel_lut_x", 0);
    push_exp(0, F_LY, "rel_lut_y", 0);
    drain();
    expect_state(0, 0, 0, 1);
    expect_state(1, 0, 0, 1);

    // Configuration a: plain motion, window edges, then the Y wall.
    for (int i = 0; i < 10; i++) pulse(0);
    expect_state(0, 10, 10, 1);
    pix(9, 10, 0, 0, 0);
    pix(10, 10, 1, 0, 0);
    pix(137, 10, 1, 127, 0);
    pix(138, 10, 0, 0, 0);
    pix(10, 73, 1, 0, 63);
    pix(10, 74, 0, 0, 0);
    for (int i = 10; i < 416; i++) pulse(0);
    expect_state(0, 416, 416, 1);
    pulse(0);
    expect_state(0, 417, 416, 2);
    pulse(0);
    expect_state(0, 418, 415, 2);

    // Configuration c: both limits at 400, so the 401st tick is a corner.
    for (int i = 0; i < 400; i++) pulse(1);
    expect_state(1, 400, 400, 1);
    pulse(1);
    expect_state(1, 400, 400, 2);

    // Configuration d: sync held active through reset release must not tick.
    @(negedge clk);
    expect_state(2, 0, 0, 1);
    set_vs(2, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) pulse(2);
    expect_state(2, 2, 2, 1);
    pulse(2);
    rst_d = 1'b1;
    set_vs(2, 1'b0);
    ms[2] = model_init();
    @(negedge clk);
    expect_state(2, 0, 0, 1);
    rst_d = 1'b0;
    @(negedge clk);
    expect_state(2, 0, 0, 1);
    set_vs(2, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) pulse(2);
    expect_state(2, 1, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
